// File: rtl/scan_loader.sv
// rtl/scan_loader.sv - serial scan frame loader/unloader wrapped around an 8-bit combinational project
// Optional feature macro: SCAN_LOADER_PARITY_EN (9-bit frames with a trailing even-parity bit)
module scan_loader #(
  parameter int MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_in,
  input  logic       scan_en,
  output logic [7:0] proj_in,
  input  logic [7:0] proj_out,
  output logic       scan_out,
  output logic       scan_out_valid,
  output logic       busy,
  output logic       frame_done,
  output logic       parity_err
);

`ifdef SCAN_LOADER_PARITY_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    LATCH   = 3'd2,
    CAPTURE = 3'd3,
    UNLOAD  = 3'd4
  } state_t;

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic [7:0] isr;
  logic [7:0] osr;
  logic       sample;
  logic       last_bit;
  logic       unload_last;
  logic       frame_ok;

  assign sample      = scan_en && (state == IDLE || state == LOAD);
  assign last_bit    = sample && (cnt == LAST_IDX);
  assign unload_last = (state == UNLOAD) && (cnt == 4'd7);

`ifdef SCAN_LOADER_PARITY_EN
  // Running XOR of the bits sampled so far; the parity bit must bring it back to 0.
  logic par_acc;

  assign frame_ok = ~(par_acc ^ scan_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_acc    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= last_bit && !frame_ok;
      if (last_bit)
        par_acc <= 1'b0;
      else if (sample)
        par_acc <= par_acc ^ scan_in;
    end
  end
`else
  assign frame_ok   = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample) state_nx = LOAD;
      LOAD:    if (last_bit) state_nx = frame_ok ? LATCH : IDLE;
      LATCH:   state_nx = CAPTURE;
      CAPTURE: state_nx = UNLOAD;
      UNLOAD:  if (unload_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The bit counter is shared: it counts frame bits while loading and unload cycles after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 4'd0;
      isr     <= 8'h00;
      osr     <= 8'h00;
      proj_in <= 8'h00;
    end else begin
      if (sample) begin
        cnt <= last_bit ? 4'd0 : cnt + 4'd1;
        if (cnt < 4'd8)
          isr <= (MSB_FIRST != 0) ? {isr[6:0], scan_in} : {scan_in, isr[7:1]};
      end
      if (state == LATCH)
        proj_in <= isr;
      if (state == CAPTURE)
        osr <= proj_out;
      if (state == UNLOAD) begin
        osr <= (MSB_FIRST != 0) ? {osr[6:0], 1'b0} : {1'b0, osr[7:1]};
        cnt <= unload_last ? 4'd0 : cnt + 4'd1;
      end
    end
  end

  assign busy           = (state == LATCH) || (state == CAPTURE) || (state == UNLOAD);
  assign scan_out_valid = (state == UNLOAD);
  assign frame_done     = unload_last;
  assign scan_out       = scan_out_valid & ((MSB_FIRST != 0) ? osr[7] : osr[0]);

endmodule
